mchan_cmd_splitter: RTL and testbench

// Consumer end of the control unit's command queue interface (cmd_req/cmd_gnt plus command fields and addresses).

---
 rtl/mchan_cmd_splitter_if.sv | 65 ++++++
 rtl/mchan_cmd_splitter.sv | 149 ++++++++++++++
 tb/tb_mchan_cmd_splitter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mchan_cmd_splitter_if.sv
// Command-queue and burst-issue handshake bundles for the command splitter.
// Each bundle carries a req/gnt pair plus its payload fields.
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 16
`endif
`ifndef MCHAN_OPC_WIDTH
`define MCHAN_OPC_WIDTH 4
`endif

interface mchan_cmd_if #(
  parameter int unsigned LW = `MCHAN_LEN_WIDTH,
  parameter int unsigned OW = `MCHAN_OPC_WIDTH,
  parameter int unsigned SW = 2,
  parameter int unsigned TW = 12,
  parameter int unsigned EW = 29
) ();
  logic          req;
  logic          gnt;
  logic [LW-1:0] len;
  logic [OW-1:0] opc;
  logic          inc;
  logic [SW-1:0] sid;
  logic [TW-1:0] tcdm_add;
  logic [EW-1:0] ext_add;

  modport master (
    output req, len, opc, inc, sid,
    output tcdm_add, ext_add,
    input  gnt
  );
  modport slave (
    input  req, len, opc, inc, sid,
    input  tcdm_add, ext_add,
    output gnt
  );
endinterface

interface mchan_trans_if #(
  parameter int unsigned LW = `MCHAN_LEN_WIDTH,
  parameter int unsigned OW = `MCHAN_OPC_WIDTH,
  parameter int unsigned SW = 2,
  parameter int unsigned TW = 12,
  parameter int unsigned EW = 29
) ();
  logic          req;
  logic          gnt;
  logic [LW-1:0] len;
  logic [OW-1:0] opc;
  logic          inc;
  logic [SW-1:0] sid;
  logic [TW-1:0] tcdm_add;
  logic [EW-1:0] ext_add;
  logic          last;

  modport master (
    output req, len, opc, inc, sid,
    output tcdm_add, ext_add, last,
    input  gnt
  );
  modport slave (
    input  req, len, opc, inc, sid,
    input  tcdm_add, ext_add, last,
    output gnt
  );
endinterface

// File: rtl/mchan_cmd_splitter.sv
// Splits 1D commands into bursts bounded by MAX_BURST_BYTES and the ext boundary.
// Optional MCHAN_SPLIT_PERF_EN adds a saturating burst counter output.
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 16
`endif
`ifndef MCHAN_OPC_WIDTH
`define MCHAN_OPC_WIDTH 4
`endif

module mchan_cmd_splitter #(
  parameter int unsigned TCDM_ADD_WIDTH  = 12,
  parameter int unsigned EXT_ADD_WIDTH   = 29,
  parameter int unsigned NB_TRANSFERS    = 4,
  parameter int unsigned TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int unsigned MCHAN_LEN_WIDTH = `MCHAN_LEN_WIDTH,
  parameter int unsigned MCHAN_OPC_WIDTH = `MCHAN_OPC_WIDTH,
  parameter int unsigned MAX_BURST_BYTES = 256,
  parameter int unsigned BOUNDARY_BYTES  = 4096
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mchan_cmd_if.slave   cmd,
  mchan_trans_if.master trans,
`ifdef MCHAN_SPLIT_PERF_EN
  output logic [31:0]  perf_bursts_o,
`endif
  output logic         busy_o
);
  localparam int unsigned LW = MCHAN_LEN_WIDTH;
  localparam int unsigned TW = TCDM_ADD_WIDTH;
  localparam int unsigned EW = EXT_ADD_WIDTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state_q;
  logic [LW:0]                rem_q;
  logic                       req_q;
  logic                       last_q;
  logic [LW-1:0]              len_q;
  logic [MCHAN_OPC_WIDTH-1:0] opc_q;
  logic                       inc_q;
  logic [TRANS_SID_WIDTH-1:0] sid_q;
  logic [TW-1:0]              tcdm_q;
  logic [EW-1:0]              ext_q;

  // rem counts bytes still owed including the burst on the bus
  function automatic logic [LW:0] chunk_f(
    input logic [LW:0]   rem,
    input logic [EW-1:0] ext,
    input logic          inc
  );
    logic [31:0] c;
    logic [31:0] b;
    c = 32'(rem);
    if (c > MAX_BURST_BYTES) c = MAX_BURST_BYTES;
    b = BOUNDARY_BYTES - 32'(ext & EW'(BOUNDARY_BYTES - 1));
    if (inc && b < c) c = b;
    return c[LW:0];
  endfunction

  logic [LW:0]   acc_rem;
  logic [LW:0]   acc_chunk;
  logic [LW:0]   cur_chunk;
  logic [LW:0]   nxt_rem;
  logic [TW-1:0] nxt_tcdm;
  logic [EW-1:0] nxt_ext;
  logic [LW:0]   nxt_chunk;

  always_comb begin
    acc_rem   = {1'b0, cmd.len} + 1'b1;
    acc_chunk = chunk_f(acc_rem, cmd.ext_add, cmd.inc);
    cur_chunk = {1'b0, len_q} + 1'b1;
    nxt_rem   = rem_q - cur_chunk;
    nxt_tcdm  = tcdm_q + TW'(cur_chunk);
    nxt_ext   = inc_q ? ext_q + EW'(cur_chunk) : ext_q;
    nxt_chunk = chunk_f(nxt_rem, nxt_ext, inc_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      req_q   <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
      opc_q   <= '0;
      inc_q   <= 1'b0;
      sid_q   <= '0;
      tcdm_q  <= '0;
      ext_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd.req) begin
            state_q <= ISSUE;
            req_q   <= 1'b1;
            rem_q   <= acc_rem;
            len_q   <= LW'(acc_chunk - 1'b1);
            last_q  <= (acc_chunk == acc_rem);
            opc_q   <= cmd.opc;
            inc_q   <= cmd.inc;
            sid_q   <= cmd.sid;
            tcdm_q  <= cmd.tcdm_add;
            ext_q   <= cmd.ext_add;
          end
        end
        ISSUE: begin
          // req low here is the bubble after the last burst
          if (!req_q) begin
            state_q <= IDLE;
          end else if (trans.gnt) begin
            if (last_q) begin
              req_q <= 1'b0;
            end else begin
              rem_q  <= nxt_rem;
              len_q  <= LW'(nxt_chunk - 1'b1);
              last_q <= (nxt_chunk == nxt_rem);
              tcdm_q <= nxt_tcdm;
              ext_q  <= nxt_ext;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.gnt        = (state_q == IDLE);
  assign busy_o         = (state_q == ISSUE);
  assign trans.req      = req_q;
  assign trans.len      = len_q;
  assign trans.opc      = opc_q;
  assign trans.inc      = inc_q;
  assign trans.sid      = sid_q;
  assign trans.tcdm_add = tcdm_q;
  assign trans.ext_add  = ext_q;
  assign trans.last     = last_q;

`ifdef MCHAN_SPLIT_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_bursts_o <= '0;
    end else if (req_q && trans.gnt && perf_bursts_o != 32'hFFFF_FFFF) begin
      perf_bursts_o <= perf_bursts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mchan_cmd_splitter.sv
// Scoreboard bench for mchan_cmd_splitter: random and directed commands
// against a byte-arithmetic burst model, with random and forced backpressure.
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 16
`endif
`ifndef MCHAN_OPC_WIDTH
`define MCHAN_OPC_WIDTH 4
`endif

module tb_mchan_cmd_splitter;
  localparam int unsigned LW = `MCHAN_LEN_WIDTH;
  localparam int unsigned OW = `MCHAN_OPC_WIDTH;
  localparam int unsigned SW = 2;
  localparam int unsigned TW = 12;
  localparam int unsigned EW = 29;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [OW-1:0] opc;
    logic          inc;
    logic [SW-1:0] sid;
    logic [TW-1:0] tcdm;
    logic [EW-1:0] ext;
    logic          last;
  } burst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [31:0] perf;

  always #5 clk = ~clk;

  mchan_cmd_if #(.LW(LW), .OW(OW), .SW(SW), .TW(TW), .EW(EW)) cmd ();
  mchan_trans_if #(.LW(LW), .OW(OW), .SW(SW), .TW(TW), .EW(EW)) tr ();

  mchan_cmd_splitter #(
    .TCDM_ADD_WIDTH(TW), .EXT_ADD_WIDTH(EW), .NB_TRANSFERS(4),
    .MCHAN_LEN_WIDTH(LW), .MCHAN_OPC_WIDTH(OW),
    .MAX_BURST_BYTES(256), .BOUNDARY_BYTES(4096)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd(cmd),
    .trans(tr),
`ifdef MCHAN_SPLIT_PERF_EN
    .perf_bursts_o(perf),
`endif
    .busy_o(busy)
  );

`ifndef MCHAN_SPLIT_PERF_EN
  assign perf = '0;
`endif

  burst_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  logic tie = 1'b0;
  logic force_low = 1'b0;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: peel bursts off the byte count with plain arithmetic
  task automatic model(input int unsigned len, input int unsigned opc,
                       input bit inc, input int unsigned sid,
                       input int unsigned tcdm, input longint unsigned ext);
    int unsigned rem = len + 1;
    int unsigned t = tcdm;
    longint unsigned e = ext;
    int unsigned c;
    burst_t b;
    while (rem > 0) begin
      c = (rem < 256) ? rem : 256;
      if (inc && (4096 - (e % 4096)) < c) c = 4096 - int'(e % 4096);
      b.len  = LW'(c - 1);
      b.opc  = OW'(opc);
      b.inc  = inc;
      b.sid  = SW'(sid);
      b.tcdm = TW'(t);
      b.ext  = EW'(e);
      b.last = (c == rem);
      exp_q.push_back(b);
      rem -= c;
      t = (t + c) % 4096;
      if (inc) e = (e + c) % (64'd1 << EW);
    end
  endtask

  function automatic burst_t cur_burst();
    burst_t b;
    b.len = tr.len; b.opc = tr.opc; b.inc = tr.inc; b.sid = tr.sid;
    b.tcdm = tr.tcdm_add; b.ext = tr.ext_add; b.last = tr.last;
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    if (force_low) tr.gnt = 1'b0;
    else if (tie) tr.gnt = 1'b1;
    else tr.gnt = ($urandom_range(0, 3) != 0);
  end

  burst_t prev_b;
  logic prev_hold = 1'b0;

  // Monitor: pops the scoreboard on every accepted burst
  always @(negedge clk) begin
    burst_t c;
    burst_t e;
    c = cur_burst();
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("req_held", tr.req, 1);
        if (tr.req) chk("hold_stable", (c == prev_b), 1);
      end
      if (tr.req && tr.gnt) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_burst: len %0h ext %0h", c.len, c.ext);
        end else begin
          e = exp_q.pop_front();
          chk("len", c.len, e.len);
          chk("ext", c.ext, e.ext);
          chk("tcdm", c.tcdm, e.tcdm);
          chk("last", c.last, e.last);
          chk("attr", {c.opc, c.inc, c.sid}, {e.opc, e.inc, e.sid});
        end
      end
      prev_hold = tr.req && !tr.gnt;
      prev_b = c;
    end
  end

  task automatic send(input int unsigned len, input int unsigned opc,
                      input bit inc, input int unsigned sid,
                      input int unsigned tcdm, input int unsigned ext);
    int k = 0;
    @(negedge clk);
    while (!cmd.gnt && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd.gnt) begin
      n_chk++;
      $display("FAIL cmd_gnt_timeout: got 0 expected 1");
    end else begin
      cmd.len = LW'(len); cmd.opc = OW'(opc); cmd.inc = inc;
      cmd.sid = SW'(sid); cmd.tcdm_add = TW'(tcdm); cmd.ext_add = EW'(ext);
      cmd.req = 1'b1;
      model(len, opc, inc, sid, tcdm, longint'(ext));
      @(posedge clk);
      #1 cmd.req = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("hs_reached", (hs_cnt >= target), 1);
  endtask

  initial begin
    int base;
    int low;
    cmd.req = 1'b0; cmd.len = '0; cmd.opc = '0; cmd.inc = 1'b0;
    cmd.sid = '0; cmd.tcdm_add = '0; cmd.ext_add = '0;
    tr.gnt = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_trans_req", tr.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", tr.len, 0);
    chk("rst_ext", tr.ext_add, 0);
    chk("rst_last", tr.last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_gnt", cmd.gnt, 1);
`ifdef MCHAN_SPLIT_PERF_EN
    chk("perf_rst", perf, 0);
`endif

    // Boundary split plus a 6-cycle forced stall mid-command
    base = hs_cnt;
    send(32'h3FF, 5, 1, 2, 32'h100, 32'hFC0);
    wait_hs(base + 2);
    force_low = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("stall_req", tr.req, 1);
    end
    force_low = 1'b0;
    wait_done();
    chk("s1_bursts", hs_cnt - base, 5);
`ifdef MCHAN_SPLIT_PERF_EN
    chk("perf_s1", perf, 5);
`endif

    base = hs_cnt;
    send(32'h1FF, 3, 0, 1, 32'h20, 32'hFF0);
    wait_done();
    chk("s2_bursts", hs_cnt - base, 2);

    tie = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 1, 1, 3, 32'h0, 32'hFFF);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd.gnt) break;
      low++;
    end
    chk("cmd_gnt_low_cycles", low, 2);
    wait_done();

    base = hs_cnt;
    send(32'hFF, 2, 1, 0, 32'hFC0, 32'h0);
    wait_done();
    chk("tcdm_wrap_bursts", hs_cnt - base, 1);

    // Reset mid-command after two bursts
    base = hs_cnt;
    send(32'h3FF, 5, 1, 2, 32'h100, 32'hFC0);
    wait_hs(base + 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", tr.req, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", cmd.gnt, 1);
`ifdef MCHAN_SPLIT_PERF_EN
    chk("perf_mid_rst", perf, 0);
`endif
    send(32'h3F, 7, 1, 1, 32'h10, 32'h1000);
    wait_done();

    tie = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int unsigned len;
      int unsigned ext;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                        : $urandom_range(0, 1500);
      ext = $urandom & 32'h1FFF_FFFF;
      if ($urandom_range(0, 1) == 1) ext = ext | 32'hF00;
      if (i == 7) ext = 32'h1FFF_FF80;
      send(len, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 4095), ext);
      if ($urandom_range(0, 2) == 0) wait_done();
    end
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
